// File: rtl/key_debounce_multi.sv
// N-channel key conditioner: 2-FF sync, integrating debounce, registered level and press/release pulses.
// Optional LONG_PRESS_EN adds a per-channel hold counter that emits a one-shot key_long pulse.
module key_debounce_multi #(
  parameter int N               = 4,
  parameter int CNT_W           = 25,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int ACTIVE_LOW      = 1,
  parameter int LONG_CYCLES     = 20000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_state,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic [N-1:0] key_long
);

  localparam logic             REL_BIT   = (ACTIVE_LOW != 0);
  localparam logic [N-1:0]     REL_LVL   = {N{REL_BIT}};
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_CYCLES);

  logic [N-1:0]     sync1_q, sync2_q;
  logic [N-1:0]     p;
  logic [N-1:0]     state_q, state_d;
  logic [N-1:0]     press_q, press_d;
  logic [N-1:0]     release_q, release_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  assign p = sync2_q ^ REL_LVL;

  // Counter only runs while the synchronized level disagrees with the accepted one.
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (p[i] != state_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          state_d[i] = p[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    press_d   = state_d & ~state_q;
    release_d = ~state_d & state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= REL_LVL;
      sync2_q   <= REL_LVL;
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= key;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign key_state   = state_q;
  assign key_press   = press_q;
  assign key_release = release_q;

`ifdef LONG_PRESS_EN
  logic [CNT_W-1:0] hcnt_q [N];
  logic [CNT_W-1:0] hcnt_d [N];
  logic [N-1:0]     long_q, long_d;

  always_comb begin
    long_d = '0;
    for (int i = 0; i < N; i++) begin
      hcnt_d[i] = '0;
      if (state_q[i]) begin
        hcnt_d[i] = (hcnt_q[i] == HOLD_MAX) ? hcnt_q[i] : hcnt_q[i] + 1'b1;
        long_d[i] = (hcnt_q[i] == HOLD_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      long_q <= '0;
      for (int i = 0; i < N; i++) hcnt_q[i] <= '0;
    end else begin
      long_q <= long_d;
      for (int i = 0; i < N; i++) hcnt_q[i] <= hcnt_d[i];
    end
  end

  assign key_long = long_q;
`else
  logic unused_hold_cfg;
  assign unused_hold_cfg = ^{HOLD_LAST, HOLD_MAX};
  assign key_long        = {N{1'b0}};
`endif

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed + randomized bench for key_debounce_multi against a sample-history reference model.
module tb_key_debounce_multi;

  localparam int N = 2;
  localparam int D = 4;
  localparam int L = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] key = '1;
  logic [N-1:0] key_state, key_press, key_release, key_long;

  always #5 clk = ~clk;

  key_debounce_multi #(
    .N(N), .CNT_W(25), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1), .LONG_CYCLES(L)
  ) dut (
    .clk(clk), .rst(rst), .key(key),
    .key_state(key_state), .key_press(key_press),
    .key_release(key_release), .key_long(key_long)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: raw samples since reset, pressed-level history per edge.
  logic [N-1:0] kq [$];
  logic [N-1:0] ph [$];
  int           n = 0;
  logic [N-1:0] st = '0, pr = '0, rl = '0, lg = '0;
  int           pe [N];
  int           dut_press_n [N];
  int           dut_rel_n [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic [N-1:0] k);
    logic [N-1:0] pv;
    logic         all_diff;
    rst = r;
    key = k;
    @(posedge clk);
    if (r) begin
      kq.delete();
      ph.delete();
      n  = 0;
      st = '0; pr = '0; rl = '0; lg = '0;
    end else begin
      n++;
      pv = (n >= 3) ? ~kq[n-3] : '0;
      ph.push_back(pv);
      kq.push_back(k);
      pr = '0; rl = '0; lg = '0;
      for (int ch = 0; ch < N; ch++) begin
`ifdef LONG_PRESS_EN
        if (st[ch] && (n - pe[ch] == L)) lg[ch] = 1'b1;
`endif
        if (n >= D) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++)
            if (ph[n-1-j][ch] == st[ch]) all_diff = 1'b0;
          if (all_diff) begin
            st[ch] = ~st[ch];
            if (st[ch]) begin
              pr[ch] = 1'b1;
              pe[ch] = n;
            end else begin
              rl[ch] = 1'b1;
            end
          end
        end
      end
    end
    #1;
    chk("key_state", 32'(key_state), 32'(st));
    chk("key_press", 32'(key_press), 32'(pr));
    chk("key_release", 32'(key_release), 32'(rl));
    chk("key_long", 32'(key_long), 32'(lg));
    for (int ch = 0; ch < N; ch++) begin
      if (key_press[ch] === 1'b1) dut_press_n[ch] = n;
      if (key_release[ch] === 1'b1) dut_rel_n[ch] = n;
    end
  endtask

  task automatic hold(input logic [N-1:0] k, input int cycles);
    for (int c = 0; c < cycles; c++) step(1'b0, k);
  endtask

  logic [N-1:0] lvl;
  int           start;
  logic [7:0]   bounce;

  initial begin
    for (int ch = 0; ch < N; ch++) begin
      pe[ch] = 0; dut_press_n[ch] = -1; dut_rel_n[ch] = -1;
    end

    // Reset with both keys held pressed; acceptance 6 edges after release of rst.
    for (int c = 0; c < 3; c++) step(1'b1, 2'b00);
    hold(2'b00, 8);
    chk("rst_press_lat0", 32'(dut_press_n[0]), 32'd6);
    chk("rst_press_lat1", 32'(dut_press_n[1]), 32'd6);
    hold(2'b11, 8);

    // Clean press on ch0.
    start = n + 1;
    hold(2'b10, 8);
    chk("clean_press_lat", 32'(dut_press_n[0] - start + 1), 32'd6);
    chk("ch1_idle", 32'(key_state[1]), 32'd0);
    hold(2'b11, 8);

    // Bounce train on ch0, then a stable hold.
    bounce = 8'b1000_1000;
    for (int c = 0; c < 8; c++) step(1'b0, {1'b1, bounce[c]});
    chk("bounce_rejected", 32'(key_state[0]), 32'd0);
    start = n + 1;
    hold(2'b10, 8);
    chk("post_bounce_lat", 32'(dut_press_n[0] - start + 1), 32'd6);

    // Release on ch0.
    start = n + 1;
    hold(2'b11, 8);
    chk("release_lat", 32'(dut_rel_n[0] - start + 1), 32'd6);

    // Simultaneous press, then reset mid-filter.
    hold(2'b00, 8);
    hold(2'b11, 8);
    hold(2'b00, 4);
    step(1'b1, 2'b00);
    start = n + 1;
    hold(2'b00, 8);
    chk("restart_lat", 32'(dut_press_n[0] - start + 1), 32'd6);
    hold(2'b11, 8);

    // Long hold on ch1, then a hold released one cycle short of the long threshold.
    hold(2'b01, 25);
    hold(2'b11, 8);
    hold(2'b01, 9);
    hold(2'b11, 10);

    // Randomized key activity with occasional resets.
    lvl = '1;
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 4) == 0) lvl[ch] = ~lvl[ch];
      if (c % 400 < 200 && $urandom_range(0, 1) == 0) lvl = (c % 800 < 400) ? '0 : lvl;
      step(($urandom_range(0, 299) == 0), lvl);
    end
    hold(2'b00, 30);
    hold(2'b11, 10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
N-channel push-button conditioner for the board-level user keys. Per channel:
- 2-FF synchronizer
- Per-channel integrating debounce counter
- Registered debounced level
- One-cycle press and release pulses
Sits between the raw key pins and the control FSMs, and supersedes the single-delay edge-sampling debouncer with a true stable-time filter.

Parameters:
N, 4, number of independent key channels (1..32)
CNT_W, 25, width of the debounce and long-press counters
DEBOUNCE_CYCLES, 200000, clk cycles the synchronized input must hold a new level before acceptance (20 ms at 10 MHz); must be >= 2 and < 2**CNT_W
ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed; 0 = reads 1 when pressed
LONG_CYCLES, 20000000, debounced-pressed cycles before long-press pulse (2 s at 10 MHz); used only with LONG_PRESS_EN; must be >= 1 and < 2**CNT_W

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
key  input  N  raw asynchronous key pins
key_state  output  N  debounced level, 1 = pressed (polarity already normalised)
key_press  output  N  one-cycle pulse on accepted press
key_release  output  N  one-cycle pulse on accepted release
key_long  output  N  one-cycle pulse on long-press; constant 0 without LONG_PRESS_EN

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - sync FFs = released level ({N{ACTIVE_LOW}})
  - counters = 0
  - key_state, key_press, key_release, key_long = 0
- Polarity: p[i] = sync2[i] XOR ACTIVE_LOW, so p = 1 means pressed. This is applied after synchronization.
- Synchronizer: sync1 <= key; sync2 <= sync1. Two cycles of latency, no reset-release glitch.
- Per-channel debounce counter cnt[i], evaluated each edge:
  - p[i] == key_state[i]: cnt[i] <= 0 (any bounce back restarts the filter).
  - p[i] != key_state[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - p[i] != key_state[i] and cnt[i] == DEBOUNCE_CYCLES-1: key_state[i] <= p[i]; cnt[i] <= 0.
- Pulses:
  - key_press[i] is registered and high exactly in the cycle key_state[i] first reads 1.
  - key_release[i] is likewise high in the cycle key_state[i] first reads 0.
  - A pulse is never longer than one cycle, and press and release are never high together on one channel.
- Latency: raw level held from sampling edge E1 → key_state changes after edge E(DEBOUNCE_CYCLES+2), i.e. 2 sync + DEBOUNCE_CYCLES filter cycles. Release latency is identical.
- Rejection:
  - Any raw pulse shorter than DEBOUNCE_CYCLES cycles (post-sync) never changes key_state.
  - A bounce train resets cnt on every return to the old level.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Counters never wrap: the compare at DEBOUNCE_CYCLES-1 bounds them.
- Reset mid-count or mid-press: all state is cleared next edge and no pulses are emitted. A key held through reset is re-accepted as a fresh press after DEBOUNCE_CYCLES+2 cycles.

Optional Feature:
Macro LONG_PRESS_EN.
- Defined:
  - Per-channel hold counter hcnt[i] is cleared while key_state[i] == 0.
  - While key_state[i] == 1, hcnt[i] increments, saturating at LONG_CYCLES.
  - key_long[i] pulses for one cycle when hcnt[i] transitions from LONG_CYCLES-1 to LONG_CYCLES, i.e. LONG_CYCLES cycles after the key_press cycle. The first counted edge is the one after key_press.
  - Exactly once per hold; no repeat.
  - A release before that clears hcnt with no pulse.
  - hcnt resets to 0 on rst.
- Undefined: no hold counters are synthesized, key_long is tied to {N{1'b0}}, and the port list is unchanged.

Test Plan:
Benches use N=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1.
1. Reset: hold rst 3 cycles with key=2'b00 → all outputs 0 during and one cycle after. Then key_press[0]/[1] both pulse at edge 6 after rst deassert (2 sync + 4 filter).
2. Clean press ch0: key[0] 1→0 sampled at E1 → key_state[0]=1 and key_press[0]=1 after E6 only. key_press low after E7; key_state[1] stays 0.
3. Bounce ch0 (pressed level 0): key[0] pattern 0,0,0,1,0,0,0,1 per cycle → key_state[0] never changes. Then hold 0 for ≥4 cycles → single key_press 6 cycles after the hold starts.
4. Release: from pressed, key[0] 0→1 held → key_release[0] one-cycle pulse 6 edges later, key_state[0]=0, key_press[0] stays 0.
5. Simultaneous: both keys pressed on the same edge → key_press=2'b11 in the same cycle. Assert rst mid-filter (cnt=2) → no pulse; acceptance restarts from 0.
6. LONG_PRESS_EN defined: hold ch1 pressed → key_long[1] pulses exactly once, 10 cycles after key_press[1]. Release at 9 cycles → no key_long. Macro undefined → key_long constant 0.
